gol_gen_sequencer: RTL and testbench

Sequences one Game-of-Life generation over a row-organised board memory of ROWS words, each WIDTH cells wide. Reads the rows in order into a three-row window (up/cur/dn) and presents the window to the external neighbour-count/compare datapath. Writes the returned next-state row back in place. Also supports single-shot and continuous (free-running) generation modes and counts completed generations.

---
 rtl/gol_pkg.sv | 19 +
 rtl/gol_row_window.sv | 40 ++++
 rtl/gol_gen_sequencer.sv | 126 ++++++++++++
 tb/tb_gol_gen_sequencer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// gol_pkg: shared state encoding, default geometry and border-mask helper for the generation sequencer.
package gol_pkg;
    localparam int GOL_ROWS      = 32;
    localparam int GOL_WIDTH     = 32;
    localparam int GOL_ADDR_W    = 5;
    localparam int GOL_GEN_W     = 16;
    localparam int GOL_MAX_WIDTH = 1024;

    typedef enum logic [2:0] {IDLE, PRIME, PWAIT, LOAD, WAIT, EVAL, DONE} state_t;

    // Low `width` bits set, except the two edge cells which are held dead.
    function automatic logic [GOL_MAX_WIDTH-1:0] border_mask(input int width);
        logic [GOL_MAX_WIDTH-1:0] m;
        m = {GOL_MAX_WIDTH{1'b1}} >> (GOL_MAX_WIDTH - width);
        m &= ~(GOL_MAX_WIDTH'(1) << (width - 1));
        m &= ~GOL_MAX_WIDTH'(1);
        return m;
    endfunction
endpackage

// File: rtl/gol_row_window.sv
// gol_row_window: three-row sliding window (up/cur/dn) over the board.
module gol_row_window #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_up_i,
    input  logic             load_cur_i,
    input  logic             load_dn_i,
    input  logic             dn_zero_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] up_o,
    output logic [WIDTH-1:0] cur_o,
    output logic [WIDTH-1:0] dn_o
);
    logic [WIDTH-1:0] up_q, up_d, cur_q, cur_d, dn_q, dn_d;

    always_comb begin
        up_d  = clr_up_i ? '0 : shift_i ? cur_q : up_q;
        cur_d = load_cur_i ? data_i : shift_i ? dn_q : cur_q;
        dn_d  = load_dn_i ? (dn_zero_i ? '0 : data_i) : dn_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_q  <= '0;
            cur_q <= '0;
            dn_q  <= '0;
        end else begin
            up_q  <= up_d;
            cur_q <= cur_d;
            dn_q  <= dn_d;
        end
    end

    assign up_o  = up_q;
    assign cur_o = cur_q;
    assign dn_o  = dn_q;
endmodule

// File: rtl/gol_gen_sequencer.sv
// gol_gen_sequencer: walks the board row by row, feeds the window to the external datapath
// and writes each masked next-state row back in place; counts completed generations.
module gol_gen_sequencer
    import gol_pkg::*;
#(
    parameter int ROWS   = GOL_ROWS,
    parameter int WIDTH  = GOL_WIDTH,
    parameter int ADDR_W = GOL_ADDR_W,
    parameter int GEN_W  = GOL_GEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              run_cont,
    output logic              busy,
    output logic              done,
    output logic [GEN_W-1:0]  gen_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  win_up,
    output logic [WIDTH-1:0]  win_cur,
    output logic [WIDTH-1:0]  win_dn,
    input  logic [WIDTH-1:0]  next_row
);
    localparam logic [WIDTH-1:0]  MASK = WIDTH'(border_mask(WIDTH));
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic [GEN_W-1:0]  gen_q, gen_d;
    logic              last, clr_up, load_cur, load_dn, dn_zero, shift;

    assign last = r_q == LAST;

    gol_row_window #(.WIDTH(WIDTH)) u_win (
        .clk       (clk),
        .rst       (rst),
        .clr_up_i  (clr_up),
        .load_cur_i(load_cur),
        .load_dn_i (load_dn),
        .dn_zero_i (dn_zero),
        .shift_i   (shift),
        .data_i    (rd_data),
        .up_o      (win_up),
        .cur_o     (win_cur),
        .dn_o      (win_dn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            gen_q   <= gen_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        gen_d    = gen_q;
        clr_up   = 1'b0;
        load_cur = 1'b0;
        load_dn  = 1'b0;
        dn_zero  = 1'b0;
        shift    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = PRIME;
                r_d     = '0;
                clr_up  = 1'b1;
            end
            PRIME: begin
                rd_en   = 1'b1;
                state_d = PWAIT;
            end
            PWAIT: begin
                load_cur = 1'b1;
                state_d  = LOAD;
            end
            // The bottom row has no successor, so no read and dn becomes zero in WAIT.
            LOAD: begin
                rd_en   = !last;
                rd_addr = last ? '0 : r_q + ADDR_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                load_dn = 1'b1;
                dn_zero = last;
                state_d = EVAL;
            end
            EVAL: begin
                wr_en   = 1'b1;
                wr_addr = r_q;
                wr_data = next_row & MASK;
                shift   = 1'b1;
                state_d = last ? DONE : LOAD;
                r_d     = last ? r_q : r_q + ADDR_W'(1);
            end
            DONE: begin
                done    = 1'b1;
                gen_d   = gen_q + GEN_W'(1);
                state_d = run_cont ? PRIME : IDLE;
                r_d     = '0;
                clr_up  = run_cont;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = state_q != IDLE;
    assign gen_count = gen_q;
endmodule

// File: tb/tb_gol_gen_sequencer.sv
// tb_gol_gen_sequencer: board memory model plus golden Life datapath; expected writes go to a
// scoreboard queue that a write monitor drains and compares.
module tb_gol_gen_sequencer;
    localparam int ROWS = 32, WIDTH = 32, AW = 5, GW = 16;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, run_cont = 1'b0;
    logic             busy, done, rd_en, wr_en, load = 1'b0, dp_ones = 1'b0;
    logic [GW-1:0]    gen_count;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [WIDTH-1:0] rd_data = '0, wr_data, win_up, win_cur, win_dn, next_row;
    logic [WIDTH-1:0] mem [ROWS];
    logic [WIDTH-1:0] img [ROWS];
    logic [63:0]      sb [$];
    logic [63:0]      e;
    int               checks = 0, errors = 0;

    always #5 clk = ~clk;

    gol_gen_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .run_cont(run_cont), .busy(busy), .done(done),
        .gen_count(gen_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .win_up(win_up),
        .win_cur(win_cur), .win_dn(win_dn), .next_row(next_row)
    );

    function automatic logic [WIDTH-1:0] life(input logic [WIDTH-1:0] u, c, d);
        logic [WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            int k;
            k = 0;
            for (int j = i - 1; j <= i + 1; j++)
                if (j >= 0 && j < WIDTH) k += int'(u[j]) + int'(d[j]) + ((j != i) ? int'(c[j]) : 0);
            n[i] = (k == 3) || (c[i] && k == 2);
        end
        return n;
    endfunction

    assign next_row = dp_ones ? '1 : life(win_up, win_cur, win_dn);

    always @(posedge clk) begin
        if (load) mem <= img;
        else if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (wr_en === 1'b1) begin
        if (wr_addr == 0) chk("win_up_row0", 64'(win_up), 64'd0);
        if (wr_addr == AW'(ROWS - 1)) chk("win_dn_last", 64'(win_dn), 64'd0);
        chk("rd_wr_overlap", 64'(rd_en), 64'd0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0h", wr_addr, wr_data);
        end else begin
            e = sb.pop_front();
            chk("wr_addr", 64'(wr_addr), {32'd0, e[63:32]});
            chk("wr_data", 64'(wr_data), {32'd0, e[31:0]});
        end
    end

    task automatic load_board();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic push_rows(input logic [WIDTH-1:0] b [ROWS], input int n);
        for (int r = 0; r < n; r++) sb.push_back({32'(r), b[r]});
    endtask

    task automatic run_gen(input int ngen, input logic [63:0] exp_gc);
        int   cyc, dcyc, reads, dones;
        logic pd;
        run_cont = ngen > 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0; dcyc = 0; reads = 0; dones = 0; pd = 1'b0;
        while (busy && cyc < 400 * ngen) begin
            cyc++;
            if (pd) chk("prime_after_done", 64'({rd_en, rd_addr}), 64'({1'b1, 5'd0}));
            pd = done;
            if (done) begin
                dones++;
                dcyc = cyc;
            end
            if (rd_en) reads++;
            if (dones == ngen - 1 && !done) run_cont = 1'b0;
            start = ngen > 1 && cyc == 150;
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", 64'(cyc), 64'(99 * ngen));
        chk("done_cycle", 64'(dcyc), 64'(99 * ngen));
        chk("done_count", 64'(dones), 64'(ngen));
        chk("read_count", 64'(reads), 64'(32 * ngen));
        chk("gen_count", 64'(gen_count), exp_gc);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    logic [WIDTH-1:0] z [ROWS];
    logic [WIDTH-1:0] x [ROWS];

    initial begin
        int n;
        for (int r = 0; r < ROWS; r++) begin
            z[r] = '0;
            img[r] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_addrs", 64'({rd_addr, wr_addr}), 64'd0);
        chk("rst_gen_count", 64'(gen_count), 64'd0);
        chk("rst_window", {win_up | win_cur | win_dn, 32'd0}, 64'd0);
        rst = 1'b0;
        load_board();
        push_rows(z, ROWS);
        run_gen(1, 1);
        img[4] = 32'h400; img[5] = 32'h400; img[6] = 32'h400;
        load_board();
        x = z; x[5] = 32'h0000_0E00;
        push_rows(x, ROWS);
        run_gen(1, 2);
        x = z; x[4] = 32'h400; x[5] = 32'h400; x[6] = 32'h400;
        push_rows(x, ROWS);
        run_gen(1, 3);
        dp_ones = 1'b1;
        for (int r = 0; r < ROWS; r++) x[r] = 32'h7FFF_FFFE;
        push_rows(x, ROWS);
        run_gen(1, 4);
        dp_ones = 1'b0;
        img = z;
        load_board();
        for (int g = 0; g < 3; g++) push_rows(z, ROWS);
        run_gen(3, 7);
        push_rows(z, 11);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(wr_en && wr_addr == 5'd10) && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("reach_row10", 64'(n < 200), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_gen_count", 64'(gen_count), 64'd0);
        chk("midrst_window", 64'(win_cur | win_up), 64'd0);
        @(negedge clk) rst = 1'b0;
        push_rows(z, ROWS);
        run_gen(1, 1);
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
